// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer-side request bus and uart_tx handshake.
// slave = arbiter side, master = producers/transmitter side.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_ready,
    output req_ack,
    output tx_data,
    output tx_start,
    output grant,
    output busy
  );

  modport master (
    output req_valid,
    output req_data,
    output tx_ready,
    input  req_ack,
    input  tx_data,
    input  tx_start,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among four producers.
// Ports: clk, rst (sync, active-high), bus (uart_tx_arbiter_if.slave).
module uart_tx_arbiter #(
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arbiter_if.slave     bus
);

  localparam int CW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] cnt;

  logic [1:0]    win;
  logic          found;
  logic [1:0]    idx;
  logic [7:0]    win_byte;

  // Search starts just past the last winner so every
  // requester is reached within four grants.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign win_byte = bus.req_data[{win, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 2'd3;
      cnt          <= '0;
      bus.req_ack  <= '0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.req_ack <= '0;
      unique case (state)
        IDLE: begin
          if (found && bus.tx_ready) begin
            bus.tx_data      <= win_byte;
            bus.req_ack[win] <= 1'b1;
            bus.grant        <= win;
            last             <= win;
            bus.tx_start     <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          // Transmitter dropping ready means it took the byte.
          if (!bus.tx_ready) begin
            bus.tx_start <= 1'b0;
            state        <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready) begin
            if (GAP_CYCLES == 0) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          bus.tx_start <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus uart_tx stub sequences.
// Stub serialises 10-bit frames at a scaled bit period.
module tb_uart_tx_arbiter;

  localparam int BIT_CYC = 16;
  localparam int LIM     = 20 * BIT_CYC + 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.GAP_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       stub_en    = 1'b0;
  logic       man_ready  = 1'b1;
  logic       stub_ready = 1'b1;
  logic [9:0] shreg      = 10'h3ff;
  logic [3:0] bitcnt     = '0;
  int         cyc        = 0;
  logic       line;

  assign bus.tx_ready = stub_en ? stub_ready : man_ready;
  assign line = stub_ready ? 1'b1 : shreg[bitcnt];

  always @(posedge clk) begin
    if (!stub_en) begin
      stub_ready <= 1'b1;
      bitcnt     <= '0;
      cyc        <= 0;
    end else if (stub_ready) begin
      if (bus.tx_start) begin
        stub_ready <= 1'b0;
        shreg      <= {1'b1, bus.tx_data, 1'b0};
        bitcnt     <= '0;
        cyc        <= 0;
      end
    end else if (cyc == BIT_CYC - 1) begin
      cyc <= 0;
      if (bitcnt == 4'd9) stub_ready <= 1'b1;
      else bitcnt <= bitcnt + 4'd1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        rdy;
    logic [3:0]  ack;
    logic        start;
    logic [7:0]  data;
    logic [1:0]  grant;
    logic        busy;
  } vec_t;

  vec_t vt[13];
  int   nrun  = 0;
  int   nfail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output logic [3:0] a,
                          output int n);
    a = '0;
    n = 0;
    while (n < LIM) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.req_ack != '0) begin
        a = bus.req_ack;
        return;
      end
    end
  endtask

  task automatic wait_ready(input logic v, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      @(posedge clk);
      #1;
      if (bus.tx_ready == v) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(
    logic r, logic [3:0] rv, logic rdy,
    logic [3:0] ack, logic st, logic [7:0] d,
    logic [1:0] g, logic b);
    vec_t v;
    v.rst = r; v.rv = rv; v.rd = 32'hA300_0055;
    v.rdy = rdy; v.ack = ack; v.start = st;
    v.data = d; v.grant = g; v.busy = b;
    return v;
  endfunction

  logic [3:0] a;
  int         n;
  logic       ok;
  int         exp_g[5];
  logic [7:0] exp_d[5];
  logic [9:0] frame;
  int         t0;
  int         pulses;

  initial begin
    vt[0]  = mk(1, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);
    vt[1]  = mk(0, 4'b0001, 1, 4'b0001, 1, 8'h55, 0, 1);
    vt[2]  = mk(0, 4'b0000, 1, 4'b0000, 1, 8'h55, 0, 1);
    vt[3]  = mk(0, 4'b0000, 0, 4'b0000, 0, 8'h55, 0, 1);
    vt[4]  = mk(0, 4'b0000, 0, 4'b0000, 0, 8'h55, 0, 1);
    vt[5]  = mk(0, 4'b0000, 1, 4'b0000, 0, 8'h55, 0, 1);
    vt[6]  = mk(0, 4'b0001, 1, 4'b0000, 0, 8'h55, 0, 1);
    vt[7]  = mk(1, 4'b0001, 1, 4'b0000, 0, 8'h00, 0, 0);
    vt[8]  = mk(0, 4'b1000, 0, 4'b0000, 0, 8'h00, 0, 0);
    vt[9]  = mk(0, 4'b1000, 0, 4'b0000, 0, 8'h00, 0, 0);
    vt[10] = mk(0, 4'b1000, 1, 4'b1000, 1, 8'hA3, 3, 1);
    vt[11] = mk(0, 4'b0000, 1, 4'b0000, 1, 8'hA3, 3, 1);
    vt[12] = mk(1, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);

    bus.req_valid = '0;
    bus.req_data  = '0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst           = vt[i].rst;
      bus.req_valid = vt[i].rv;
      bus.req_data  = vt[i].rd;
      man_ready     = vt[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
        {16'h0, bus.req_ack, bus.tx_start, bus.tx_data,
         bus.grant, bus.busy},
        {16'h0, vt[i].ack, vt[i].start, vt[i].data,
         vt[i].grant, vt[i].busy});
    end

    // Full contention through the stub transmitter.
    @(negedge clk);
    rst       = 1'b0;
    man_ready = 1'b1;
    stub_en   = 1'b1;
    pulse_rst();
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
    bus.req_data  = 32'h4443_4241;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(a, n);
      check($sformatf("rr_ack%0d", i), 32'(a),
            32'(4'b0001 << exp_g[i]));
      check($sformatf("rr_data%0d", i),
            32'(bus.tx_data), 32'(exp_d[i]));
      if (i > 0) check($sformatf("rr_gap%0d", i),
                       32'(n >= 16), 32'd1);
      if (i < 4) begin
        wait_ready(1'b0, ok);
        wait_ready(1'b1, ok);
      end
    end
    bus.req_valid = '0;
    wait_idle(ok);
    check("rr_idle", 32'(ok), 32'd1);

    // Two requesters held: strict alternation.
    pulse_rst();
    bus.req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a, n);
      check($sformatf("fair_ack%0d", i), 32'(a),
            (i % 2 == 0) ? 32'h1 : 32'h4);
      @(posedge clk);
      #1;
      check($sformatf("fair_pulse%0d", i),
            32'(bus.req_ack), 32'h0);
    end
    bus.req_valid = '0;
    wait_idle(ok);

    // Reset while waiting for frame completion.
    pulse_rst();
    bus.req_data  = 32'h0000_2200;
    bus.req_valid = 4'b0010;
    wait_ack(a, n);
    check("mid_ack", 32'(a), 32'h2);
    bus.req_valid = '0;
    wait_ready(1'b0, ok);
    @(posedge clk);
    #1;
    check("mid_wait", {30'h0, bus.tx_start, bus.busy},
          32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst",
      {24'h0, bus.req_ack, bus.tx_start, bus.busy, bus.grant},
      32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    wait_ack(a, n);
    check("mid_first", 32'(a), 32'h1);
    bus.req_valid = '0;
    wait_idle(ok);

    // Requester 1 sends 'K' over the serial line.
    pulse_rst();
    bus.req_data  = 32'h0000_4B00;
    bus.req_valid = 4'b0010;
    wait_ack(a, n);
    pulses = a[1] ? 1 : 0;
    bus.req_valid = '0;
    frame = '0;
    t0 = -1;
    for (int c = 0; c < 14 * BIT_CYC; c++) begin
      @(posedge clk);
      #1;
      if (bus.req_ack[1]) pulses++;
      if (t0 < 0 && line == 1'b0) t0 = c;
      if (t0 >= 0 && c - t0 >= BIT_CYC / 2 &&
          (c - t0 - BIT_CYC / 2) % BIT_CYC == 0 &&
          (c - t0 - BIT_CYC / 2) / BIT_CYC < 10)
        frame[(c - t0 - BIT_CYC / 2) / BIT_CYC] = line;
    end
    check("sys_frame", 32'(frame), 32'h296);
    check("sys_pulses", 32'(pulses), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
